alu_serial_seq: RTL and testbench
=================================

Name: alu_serial_seq

Overview:
- Multi-cycle sequencer that drives a 1-bit ALU slice one bit per clock, LSB first, to produce a full WIDTH-bit ALU result.
- Owns everything outside the slice: operand shift registers, carry feedback between cycles, overflow and SLT set recovery, result assembly, and valid/ready handshakes.
- Used as a small-area ALU alternative on the lab datapath, sitting between the decode/register-read stage and write-back.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 2..64.
- CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk_i  input  1  system clock; all state updates on rising edge
- rst_i  input  1  synchronous reset, active-low; sampled on rising edge of clk_i
- in_valid  input  1  operands and ALU_control valid
- in_ready  output  1  sequencer can accept a new operation
- src1  input  WIDTH  operand A
- src2  input  WIDTH  operand B
- ALU_control  input  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR; others illegal
- out_valid  output  1  result fields valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  computed word
- zero  output  1  result == 0
- cout  output  1  carry out of MSB (ADD/SUB/SLT only)
- overflow  output  1  signed overflow (ADD/SUB only)

Behaviour:
- Decode per op: A_invert = (op==NOR); B_invert = (op in SUB, SLT, NOR); initial carry = B_invert for SUB/SLT, else 0; slice operation 00 AND, 01 OR, 10 ADD/SUB/SLT.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE: in_ready=1. When in_valid is high, latch src1, src2, op; clear bit counter; load initial carry; go to RUN.
- RUN:
  - Each cycle, feed bit[cnt] of both operand registers plus the carry register to the slice.
  - Shift the slice result into result bit[cnt]; carry register takes the slice carry-out.
  - When cnt==WIDTH-1, capture carry-in of MSB and carry-out of MSB.
  - After the MSB cycle: SLT goes to FIX; all other ops go to DONE.
- FIX (SLT only): set = MSB sum XOR (carry-in MSB XOR carry-out MSB); result = {WIDTH-1 zeros, set}; go to DONE.
- DONE:
  - out_valid=1. result, zero, cout and overflow are registered and held stable until out_ready is high.
  - On out_valid & out_ready, go to IDLE. There is no direct DONE->RUN path; one IDLE cycle separates operations.
- Latency from accept to out_valid: WIDTH+1 cycles for non-SLT ops, WIDTH+2 for SLT. Throughput is one op per WIDTH+2 (or WIDTH+3) cycles.
- overflow = carry-in MSB XOR carry-out MSB for ADD/SUB; 0 otherwise.
- cout = 0 for AND/OR/NOR.
- Illegal ALU_control: the op completes via the normal path with result=0, zero=1, cout=0, overflow=0.
- in_valid while not IDLE is ignored; in_ready=0 in RUN, FIX and DONE.
- Reset (any state, including mid-RUN): state=IDLE, in_ready=1, out_valid=0, result=0, zero=0, cout=0, overflow=0, counter=0, carry=0. Any partial result is discarded.

Optional Feature:
- Macro: ALU_SERIAL_LOGIC_BYPASS_EN.
- Defined: AND/OR/NOR are computed word-parallel in IDLE at accept time and go straight to DONE; latency is 1 cycle. Arithmetic ops are unchanged.
- Undefined: every op is bit-serial as described above.

Decomposition:
- Shared package alu_pkg holds:
  - 4-bit ALU_control encodings (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR).
  - 2-bit slice operation codes.
  - FSM state encoding.
- One natural sub-module: alu_serial_slice, a 1-bit slice with invert, carry and 2-bit operation select, instantiated once and reused every cycle.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow=1, cout=0, zero=0, out_valid 33 cycles after accept.
- SUB 0x00000005 - 0x00000005 -> result 0, zero=1, cout=1, overflow=0.
- SLT 0x80000000 vs 0x00000001 -> result 0x00000001, out_valid 34 cycles after accept. SLT 0x7FFFFFFF vs 0xFFFFFFFF -> result 0.
- NOR 0x0F0F0F0F, 0x00FF00FF -> result 0xF000F000. With ALU_SERIAL_LOGIC_BYPASS_EN defined, out_valid comes 1 cycle after accept.
- Backpressure: out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready=0, a new in_valid is ignored. Release out_ready -> IDLE, then the next op is accepted.
- Drop rst_i to 0 at cycle 12 of an ADD -> next edge: out_valid=0, result=0, in_ready=1. A following ADD 3+4 -> 7.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU sequencer: ALU_control codes,
// 1-bit slice operation codes, FSM states and the per-op decode helper.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] SL_AND   = 2'b00;
    localparam logic [1:0] SL_OR    = 2'b01;
    localparam logic [1:0] SL_ARITH = 2'b10;
    localparam logic [1:0] SL_NONE  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    typedef struct packed {
        logic       a_inv;
        logic       b_inv;
        logic       cin;
        logic [1:0] sl_op;
        logic       arith;
        logic       ovf_en;
        logic       is_slt;
    } dec_t;

    // Illegal codes select SL_NONE so the slice emits zeros on every bit.
    function automatic dec_t alu_decode(input logic [3:0] op);
        dec_t d;
        d       = '0;
        d.sl_op = SL_NONE;
        case (op)
            ALU_AND: d.sl_op = SL_AND;
            ALU_OR:  d.sl_op = SL_OR;
            ALU_ADD: begin
                d.sl_op  = SL_ARITH;
                d.arith  = 1'b1;
                d.ovf_en = 1'b1;
            end
            ALU_SUB: begin
                d.sl_op  = SL_ARITH;
                d.b_inv  = 1'b1;
                d.cin    = 1'b1;
                d.arith  = 1'b1;
                d.ovf_en = 1'b1;
            end
            ALU_SLT: begin
                d.sl_op  = SL_ARITH;
                d.b_inv  = 1'b1;
                d.cin    = 1'b1;
                d.arith  = 1'b1;
                d.is_slt = 1'b1;
            end
            ALU_NOR: begin
                d.sl_op = SL_AND;
                d.a_inv = 1'b1;
                d.b_inv = 1'b1;
            end
            default: ;
        endcase
        return d;
    endfunction

    function automatic logic is_logic_op(input logic [3:0] op);
        return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_NOR);
    endfunction

endpackage

// File: rtl/alu_serial_slice.sv
// 1-bit ALU slice: optional operand inversion, AND/OR/full-add select.
module alu_serial_slice
    import alu_pkg::*;
(
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_a_inv,
    input  logic       i_b_inv,
    input  logic       i_cin,
    input  logic [1:0] i_op,
    output logic       o_res,
    output logic       o_cout
);

    logic w_a;
    logic w_b;

    assign w_a    = i_a ^ i_a_inv;
    assign w_b    = i_b ^ i_b_inv;
    assign o_cout = (w_a & w_b) | (i_cin & (w_a ^ w_b));

    always_comb begin
        o_res = 1'b0;
        case (i_op)
            SL_AND:   o_res = w_a & w_b;
            SL_OR:    o_res = w_a | w_b;
            SL_ARITH: o_res = w_a ^ w_b ^ i_cin;
            default:  o_res = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: drives one alu_serial_slice LSB first and assembles
// a WIDTH-bit result. Define ALU_SERIAL_LOGIC_BYPASS_EN for 1-cycle AND/OR/NOR.
//
// state | meaning
// IDLE  | in_ready=1, waiting for in_valid
// RUN   | one operand bit per clock through the slice
// FIX   | SLT only: fold MSB sum and overflow into the set bit
// DONE  | out_valid=1, outputs held until out_ready
module alu_serial_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       ALU_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic [WIDTH-2:0] r_acc;
    logic             r_cin_msb;
    logic             r_cout_msb;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_cout;
    logic             r_ovf;

    dec_t             w_dec;
    dec_t             w_in_dec;
    logic             w_slice_res;
    logic             w_slice_cout;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_set;

    assign w_dec      = alu_decode(r_op);
    assign w_in_dec   = alu_decode(ALU_control);
    // Slice output enters at the top; after WIDTH shifts bit 0 lands at [0].
    assign w_acc_next = {w_slice_res, r_acc};
    assign w_set      = r_acc[WIDTH-2] ^ r_cin_msb ^ r_cout_msb;

`ifdef ALU_SERIAL_LOGIC_BYPASS_EN
    logic [WIDTH-1:0] w_bypass;

    always_comb begin
        w_bypass = '0;
        case (ALU_control)
            ALU_AND: w_bypass = src1 & src2;
            ALU_OR:  w_bypass = src1 | src2;
            ALU_NOR: w_bypass = ~(src1 | src2);
            default: w_bypass = '0;
        endcase
    end
`endif

    alu_serial_slice u_slice (
        .i_a     (r_a[0]),
        .i_b     (r_b[0]),
        .i_a_inv (w_dec.a_inv),
        .i_b_inv (w_dec.b_inv),
        .i_cin   (r_carry),
        .i_op    (w_dec.sl_op),
        .o_res   (w_slice_res),
        .o_cout  (w_slice_cout)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_acc       <= '0;
            r_cin_msb   <= 1'b0;
            r_cout_msb  <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a        <= src1;
                        r_b        <= src2;
                        r_op       <= ALU_control;
                        r_cnt      <= '0;
                        r_carry    <= w_in_dec.cin;
                        r_acc      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_RUN;
`ifdef ALU_SERIAL_LOGIC_BYPASS_EN
                        if (is_logic_op(ALU_control)) begin
                            r_result    <= w_bypass;
                            r_zero      <= (w_bypass == '0);
                            r_cout      <= 1'b0;
                            r_ovf       <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end
`endif
                    end
                end
                ST_RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_acc   <= w_acc_next[WIDTH-1:1];
                    r_carry <= w_slice_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_BIT) begin
                        r_cin_msb  <= r_carry;
                        r_cout_msb <= w_slice_cout;
                        if (w_dec.is_slt) begin
                            r_state <= ST_FIX;
                        end else begin
                            r_result    <= w_acc_next;
                            r_zero      <= (w_acc_next == '0);
                            r_cout      <= w_dec.arith & w_slice_cout;
                            r_ovf       <= w_dec.ovf_en & (r_carry ^ w_slice_cout);
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                    end
                end
                ST_FIX: begin
                    r_result    <= {{(WIDTH-1){1'b0}}, w_set};
                    r_zero      <= ~w_set;
                    r_cout      <= r_cout_msb;
                    r_ovf       <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign cout      = r_cout;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed plus random bench for alu_serial_seq against an arithmetic reference model.
module tb_alu_serial_seq;

    localparam int W = 32;

    logic         clk_i       = 1'b0;
    logic         rst_i       = 1'b0;
    logic         in_valid    = 1'b0;
    logic         out_ready   = 1'b0;
    logic [W-1:0] src1        = '0;
    logic [W-1:0] src2        = '0;
    logic [3:0]   ALU_control = 4'b0000;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         zero;
    logic         cout;
    logic         overflow;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    alu_serial_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .src1        (src1),
        .src2        (src2),
        .ALU_control (ALU_control),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .cout        (cout),
        .overflow    (overflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain two's-complement arithmetic on a W+1 bit sum.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [3:0] op, output logic [W-1:0] r,
                                  output logic z, output logic c, output logic v,
                                  output int lat);
        logic [W:0] s;
        r   = '0;
        c   = 1'b0;
        v   = 1'b0;
        lat = W + 1;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b1100: r = ~(a | b);
            4'b0010: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0];
                c = s[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'b0110: begin
                s = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
                r = s[W-1:0];
                c = s[W];
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'b0111: begin
                s   = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
                c   = s[W];
                r   = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
                lat = W + 2;
            end
            default: ;
        endcase
`ifdef ALU_SERIAL_LOGIC_BYPASS_EN
        if (op == 4'b0000 || op == 4'b0001 || op == 4'b1100) lat = 1;
`endif
        z = (r == '0);
    endfunction

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                            input string tag);
        @(negedge clk_i);
        check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        src1        = a;
        src2        = b;
        ALU_control = op;
        in_valid    = 1'b1;
        @(posedge clk_i);
        #1;
        in_valid = 1'b0;
    endtask

    // Called right after start_op; hold>0 keeps out_ready low and pokes in_valid meanwhile.
    task automatic finish_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                             input string tag, input int hold);
        logic [W-1:0] er;
        logic         ez, ec, ev;
        int           elat;
        int           lat;
        model(a, b, op, er, ez, ec, ev, elat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(elat));
        check({tag, "_result"}, 64'(result), 64'(er));
        check({tag, "_zero"}, 64'(zero), 64'(ez));
        check({tag, "_cout"}, 64'(cout), 64'(ec));
        check({tag, "_overflow"}, 64'(overflow), 64'(ev));
        check({tag, "_busy"}, 64'(in_ready), 64'(0));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            src1        = $urandom;
            src2        = $urandom;
            ALU_control = 4'b0110;
            in_valid    = 1'b1;
            @(posedge clk_i);
            #1;
            check({tag, "_hold_result"}, 64'(result), 64'(er));
            check({tag, "_hold_valid"}, 64'(out_valid), 64'(1));
            check({tag, "_hold_ready"}, 64'(in_ready), 64'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk_i);
        #1;
        out_ready = 1'b0;
        check({tag, "_release_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_release_ready"}, 64'(in_ready), 64'(1));
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                          input string tag);
        start_op(a, b, op, tag);
        finish_op(a, b, op, tag, 0);
    endtask

    initial begin
        logic [3:0]   ops [7];
        logic [W-1:0] a, b;
        logic [3:0]   op;
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1011};

        repeat (3) @(posedge clk_i);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_result", 64'(result), 64'(0));
        check("rst_zero", 64'(zero), 64'(0));
        check("rst_cout", 64'(cout), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        @(negedge clk_i);
        rst_i = 1'b1;

        run_op(32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, "add_ovf");
        run_op(32'h0000_0005, 32'h0000_0005, 4'b0110, "sub_zero");
        run_op(32'h8000_0000, 32'h0000_0001, 4'b0111, "slt_neg");
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 4'b0111, "slt_pos");
        run_op(32'h0F0F_0F0F, 32'h00FF_00FF, 4'b1100, "nor");
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 4'b0010, "add_carry");
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 4'b1011, "illegal");

        start_op(32'h1234_5678, 32'h0F0F_0F0F, 4'b0010, "bp");
        finish_op(32'h1234_5678, 32'h0F0F_0F0F, 4'b0010, "bp", 10);
        run_op(32'hA5A5_A5A5, 32'h5A5A_5A5A, 4'b0001, "after_bp");

        start_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 4'b0010, "rst_mid");
        repeat (11) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'(0));
        check("mid_rst_result", 64'(result), 64'(0));
        check("mid_rst_in_ready", 64'(in_ready), 64'(1));
        rst_i = 1'b1;
        run_op(32'h0000_0003, 32'h0000_0004, 4'b0010, "add_3_4");

        for (int i = 0; i < 40; i++) begin
            a  = $urandom;
            b  = (i % 8 == 0) ? a : $urandom;
            op = ops[$urandom_range(0, 6)];
            run_op(a, b, op, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
